timer_multi: RTL and testbench

- Parametrised successor to the single free-running interrupt timer. Provides NCH independent down-counting channels that share one prescaler.
- Each channel supports one-shot or periodic mode, a programmable reload value, a per-channel interrupt enable and a sticky pending flag.
- Software drives it through a word-addressed register port on the CPU data bus. It feeds one combined level irq_pin to the CPU interrupt logic, gated by global_int_en.

---
 rtl/timer_multi_pkg.sv | 24 ++
 rtl/timer_channel.sv | 77 +++++++
 rtl/timer_multi.sv | 101 ++++++++++
 tb/tb_timer_multi.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_multi_pkg.sv
// rtl/timer_multi_pkg.sv - shared register offsets and CTRL bit positions for timer_multi
package timer_multi_pkg;

  // Per-channel register offsets within each 4-word channel block
  localparam int OFS_CTRL  = 0;
  localparam int OFS_LOAD  = 1;
  localparam int OFS_COUNT = 2;

  // Global register offsets relative to the global base 4*NCH
  localparam int OFS_STATUS   = 0;
  localparam int OFS_PRESCALE = 1;

  // CTRL register layout
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;
  localparam int CTRL_W        = 3;

  // Word address of a channel register
  function automatic int chan_reg_addr(input int ch, input int ofs);
    return 4 * ch + ofs;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counting timer channel with reload and expiry logic
module timer_channel
  import timer_multi_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              i_tick,
  input  logic              i_ctrl_we,
  input  logic [CTRL_W-1:0] i_ctrl_wdata,
  input  logic              i_load_we,
  input  logic [CNT_W-1:0]  i_load_wdata,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [CNT_W-1:0]  o_load,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_expire
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_load;
  logic [CNT_W-1:0]  r_count;

  logic w_en;
  logic w_periodic;
  logic w_en_rise;
  logic w_expire;

  assign w_en       = r_ctrl[CTRL_EN];
  assign w_periodic = r_ctrl[CTRL_PERIODIC];
  assign w_en_rise  = i_ctrl_we & i_ctrl_wdata[CTRL_EN] & ~w_en;
  // Expiry looks at the pre-write EN so a software reload cannot hide it
  assign w_expire   = w_en & i_tick & (r_count == '0);

  // CTRL: software write wins; a one-shot expiry drops EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ctrl <= '0;
    end else if (i_ctrl_we) begin
      r_ctrl <= i_ctrl_wdata;
    end else if (w_expire && !w_periodic) begin
      r_ctrl[CTRL_EN] <= 1'b0;
    end
  end

  // LOAD: plain software register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_load <= '0;
    end else if (i_load_we) begin
      r_load <= i_load_wdata;
    end
  end

  // COUNT: enable reload, then LOAD write, then tick-driven decrement/reload
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_count <= '0;
    end else if (w_en_rise) begin
      r_count <= r_load;
    end else if (i_load_we) begin
      r_count <= i_load_wdata;
    end else if (w_en && i_tick) begin
      if (r_count != '0) begin
        r_count <= r_count - CNT_W'(1);
      end else if (w_periodic) begin
        r_count <= r_load;
      end
    end
  end

  assign o_ctrl   = r_ctrl;
  assign o_load   = r_load;
  assign o_count  = r_count;
  assign o_expire = w_expire;

endmodule

// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - NCH timer channels sharing one prescaler, with combined interrupt
module timer_multi
  import timer_multi_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              global_int_en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irq_pin
);

  localparam int GBASE = 4 * NCH;

  logic [PRE_W-1:0]  r_prescale;
  logic [PRE_W-1:0]  r_pcnt;
  logic [NCH-1:0]    r_pending;
  logic              w_tick;
  logic              w_status_we;
  logic              w_prescale_we;
  logic [NCH-1:0]    w_expire;
  logic [NCH-1:0]    w_ie;
  logic [CTRL_W-1:0] w_ctrl  [NCH];
  logic [CNT_W-1:0]  w_load  [NCH];
  logic [CNT_W-1:0]  w_count [NCH];

  assign w_status_we   = we && (addr == ADDR_W'(GBASE + OFS_STATUS));
  assign w_prescale_we = we && (addr == ADDR_W'(GBASE + OFS_PRESCALE));
  assign w_tick        = (r_pcnt == r_prescale);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic w_ctrl_we;
    logic w_load_we;

    assign w_ctrl_we = we && (addr == ADDR_W'(chan_reg_addr(c, OFS_CTRL)));
    assign w_load_we = we && (addr == ADDR_W'(chan_reg_addr(c, OFS_LOAD)));
    assign w_ie[c]   = w_ctrl[c][CTRL_IE];

    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk          (clk),
      .clrn         (clrn),
      .i_tick       (w_tick),
      .i_ctrl_we    (w_ctrl_we),
      .i_ctrl_wdata (wdata[CTRL_W-1:0]),
      .i_load_we    (w_load_we),
      .i_load_wdata (wdata[CNT_W-1:0]),
      .o_ctrl       (w_ctrl[c]),
      .o_load       (w_load[c]),
      .o_count      (w_count[c]),
      .o_expire     (w_expire[c])
    );
  end

  // Prescaler: counts 0..PRESCALE, restarts whenever PRESCALE is rewritten
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_prescale <= '0;
      r_pcnt     <= '0;
    end else if (w_prescale_we) begin
      r_prescale <= wdata[PRE_W-1:0];
      r_pcnt     <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PRE_W'(1);
    end
  end

  // Sticky pending: W1C from software, hardware set wins on collision
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_pending <= '0;
    end else if (w_status_we) begin
      r_pending <= (r_pending & ~wdata[NCH-1:0]) | w_expire;
    end else begin
      r_pending <= r_pending | w_expire;
    end
  end

  // Read mux: unmapped, reserved and unused upper bits read as zero
  always_comb begin
    rdata = '0;
    for (int c = 0; c < NCH; c++) begin
      if (addr == ADDR_W'(chan_reg_addr(c, OFS_CTRL)))  rdata = 32'(w_ctrl[c]);
      if (addr == ADDR_W'(chan_reg_addr(c, OFS_LOAD)))  rdata = 32'(w_load[c]);
      if (addr == ADDR_W'(chan_reg_addr(c, OFS_COUNT))) rdata = 32'(w_count[c]);
    end
    if (addr == ADDR_W'(GBASE + OFS_STATUS))   rdata = 32'(r_pending);
    if (addr == ADDR_W'(GBASE + OFS_PRESCALE)) rdata = 32'(r_prescale);
  end

  assign irq_pin = global_int_en & (|(r_pending & w_ie));

endmodule

// File: tb/tb_timer_multi.sv
// tb/tb_timer_multi.sv - self-checking bench for timer_multi against a behavioural model
module tb_timer_multi;

  localparam int NCH = 2;
  localparam logic [3:0] A_CTRL0 = 4'd0, A_LOAD0 = 4'd1, A_CNT0 = 4'd2;
  localparam logic [3:0] A_CTRL1 = 4'd4, A_LOAD1 = 4'd5, A_CNT1 = 4'd6;
  localparam logic [3:0] A_STATUS = 4'd8, A_PRE = 4'd9;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        global_int_en = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq_pin;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [2:0]     m_ctrl  [NCH];
  logic [31:0]    m_load  [NCH];
  logic [31:0]    m_count [NCH];
  logic [NCH-1:0] m_pend;
  logic [15:0]    m_pre;
  logic [15:0]    m_pcnt;

  timer_multi #(.NCH(NCH), .CNT_W(32), .PRE_W(16), .ADDR_W(4)) dut (
    .clk           (clk),
    .clrn          (clrn),
    .global_int_en (global_int_en),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .irq_pin       (irq_pin)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ctrl[c] = '0; m_load[c] = '0; m_count[c] = '0;
    end
    m_pend = '0; m_pre = '0; m_pcnt = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    int c;
    int off;
    c = int'(a) / 4;
    off = int'(a) % 4;
    if (int'(a) < 4 * NCH) begin
      case (off)
        0: return {29'd0, m_ctrl[c]};
        1: return m_load[c];
        2: return m_count[c];
        default: return 32'd0;
      endcase
    end
    if (int'(a) == 4 * NCH)     return 32'(m_pend);
    if (int'(a) == 4 * NCH + 1) return 32'(m_pre);
    return 32'd0;
  endfunction

  function automatic logic m_irq();
    logic any;
    any = 1'b0;
    for (int c = 0; c < NCH; c++) any = any | (m_pend[c] & m_ctrl[c][2]);
    return global_int_en & any;
  endfunction

  // One clock: apply the channel rules to the model, advance the DUT, compare outputs
  task automatic step();
    logic           tick, cw, lw, en, per, exp_c;
    logic [2:0]     nctrl  [NCH];
    logic [31:0]    nload  [NCH];
    logic [31:0]    ncount [NCH];
    logic [NCH-1:0] setm;
    logic [NCH-1:0] npend;
    logic [15:0]    npre, npcnt;
    tick = (m_pcnt == m_pre);
    setm = '0;
    for (int c = 0; c < NCH; c++) begin
      cw  = we && (int'(addr) == 4 * c);
      lw  = we && (int'(addr) == 4 * c + 1);
      en  = m_ctrl[c][0];
      per = m_ctrl[c][1];
      exp_c = en && tick && (m_count[c] == 0);
      setm[c] = exp_c;
      nload[c]  = lw ? wdata : m_load[c];
      nctrl[c]  = cw ? wdata[2:0] : ((exp_c && !per) ? (m_ctrl[c] & 3'b110) : m_ctrl[c]);
      ncount[c] = m_count[c];
      if (cw && wdata[0] && !en)  ncount[c] = m_load[c];
      else if (lw)                ncount[c] = wdata;
      else if (en && tick)        ncount[c] = (m_count[c] != 0) ? m_count[c] - 1 : (per ? m_load[c] : 32'd0);
    end
    npend = m_pend;
    if (we && int'(addr) == 4 * NCH) npend = npend & ~wdata[NCH-1:0];
    npend = npend | setm;
    if (we && int'(addr) == 4 * NCH + 1) begin
      npre = wdata[15:0]; npcnt = '0;
    end else begin
      npre = m_pre; npcnt = tick ? 16'd0 : m_pcnt + 16'd1;
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      m_ctrl[c] = nctrl[c]; m_load[c] = nload[c]; m_count[c] = ncount[c];
    end
    m_pend = npend; m_pre = npre; m_pcnt = npcnt;
    n_tests++;
    if (irq_pin !== m_irq()) begin
      n_fail++;
      $display("FAIL step_irq: got %b expected %b at %0t", irq_pin, m_irq(), $time);
    end
    n_tests++;
    if (rdata !== m_read(addr)) begin
      n_fail++;
      $display("FAIL step_rdata addr=%0d: got %h expected %h at %0t", addr, rdata, m_read(addr), $time);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic quiesce();
    wr(A_CTRL0, 32'd0);
    wr(A_CTRL1, 32'd0);
    wr(A_STATUS, 32'd3);
    wr(A_PRE, 32'd0);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), v);
      n_tests++;
      if (v !== 32'd0) begin
        n_fail++; $display("FAIL reset_read addr=%0d: got %h expected 0", a, v);
      end
    end
    n_tests++;
    if (irq_pin !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: got %b expected 0", irq_pin);
    end
    @(posedge clk);
    #1;
    clrn = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_periodic();
    logic [31:0] v;
    quiesce();
    global_int_en = 1'b1;
    wr(A_LOAD0, 32'd4);
    wr(A_CTRL0, 32'd7);
    for (int i = 1; i <= 5; i++) begin
      step();
      rd(A_STATUS, v);
      n_tests++;
      if (v[0] !== (i == 5)) begin
        n_fail++; $display("FAIL periodic_first cycle=%0d: got %b expected %b", i, v[0], (i == 5));
      end
    end
    n_tests++;
    if (irq_pin !== 1'b1) begin
      n_fail++; $display("FAIL periodic_irq_set: got %b expected 1", irq_pin);
    end
    wr(A_STATUS, 32'd1);
    n_tests++;
    if (irq_pin !== 1'b0) begin
      n_fail++; $display("FAIL periodic_irq_clr: got %b expected 0", irq_pin);
    end
    for (int i = 7; i <= 10; i++) begin
      step();
      n_tests++;
      if (irq_pin !== (i == 10)) begin
        n_fail++; $display("FAIL periodic_second cycle=%0d: got %b expected %b", i, irq_pin, (i == 10));
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    quiesce();
    global_int_en = 1'b1;
    wr(A_PRE, 32'd2);
    wr(A_LOAD1, 32'd3);
    step();
    wr(A_CTRL1, 32'd5);
    for (int i = 1; i <= 12; i++) begin
      step();
      rd(A_STATUS, v);
      n_tests++;
      if (v[1] !== (i == 12)) begin
        n_fail++; $display("FAIL oneshot_expiry cycle=%0d: got %b expected %b", i, v[1], (i == 12));
      end
    end
    n_tests++;
    if (irq_pin !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_irq: got %b expected 1", irq_pin);
    end
    rd(A_CTRL1, v);
    n_tests++;
    if (v !== 32'h4) begin
      n_fail++; $display("FAIL oneshot_ctrl: got %h expected 4", v);
    end
    wr(A_STATUS, 32'd2);
    repeat (20) step();
    rd(A_STATUS, v);
    n_tests++;
    if (v !== 32'd0) begin
      n_fail++; $display("FAIL oneshot_no_repeat: got %h expected 0", v);
    end
    rd(A_CNT1, v);
    n_tests++;
    if (v !== 32'd0) begin
      n_fail++; $display("FAIL oneshot_count: got %h expected 0", v);
    end
  endtask

  task automatic test_masking();
    logic [31:0] v;
    quiesce();
    global_int_en = 1'b1;
    wr(A_LOAD0, 32'd1);
    wr(A_CTRL0, 32'd3);
    repeat (2) step();
    rd(A_STATUS, v);
    n_tests++;
    if (v[0] !== 1'b1 || irq_pin !== 1'b0) begin
      n_fail++; $display("FAIL mask_ie: got pend=%b irq=%b expected pend=1 irq=0", v[0], irq_pin);
    end
    global_int_en = 1'b0;
    wr(A_CTRL0, 32'd7);
    n_tests++;
    if (irq_pin !== 1'b0) begin
      n_fail++; $display("FAIL mask_global: got %b expected 0", irq_pin);
    end
    global_int_en = 1'b1;
    #1;
    n_tests++;
    if (irq_pin !== 1'b1) begin
      n_fail++; $display("FAIL mask_global_release: got %b expected 1", irq_pin);
    end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    quiesce();
    wr(A_LOAD0, 32'd4);
    wr(A_CTRL0, 32'd3);
    repeat (4) step();
    wr(A_STATUS, 32'd1);
    rd(A_STATUS, v);
    n_tests++;
    if (v[0] !== 1'b1) begin
      n_fail++; $display("FAIL collision_w1c: got %b expected 1", v[0]);
    end
    wr(A_STATUS, 32'd1);
    rd(A_STATUS, v);
    n_tests++;
    if (v[0] !== 1'b0) begin
      n_fail++; $display("FAIL collision_clear: got %b expected 0", v[0]);
    end
    repeat (3) step();
    wr(A_LOAD0, 32'd9);
    rd(A_CNT0, v);
    n_tests++;
    if (v !== 32'd9) begin
      n_fail++; $display("FAIL collision_load_count: got %h expected 9", v);
    end
    rd(A_STATUS, v);
    n_tests++;
    if (v[0] !== 1'b1) begin
      n_fail++; $display("FAIL collision_load_pend: got %b expected 1", v[0]);
    end
  endtask

  task automatic test_independence();
    logic [31:0] v;
    logic [31:0] exp_v;
    quiesce();
    wr(A_LOAD0, 32'd2);
    wr(A_LOAD1, 32'd6);
    wr(A_CTRL0, 32'd3);
    wr(A_CTRL1, 32'd3);
    for (int n = 2; n <= 8; n++) begin
      step();
      rd(A_STATUS, v);
      exp_v = {30'd0, (n >= 8), (n >= 3)};
      n_tests++;
      if (v !== exp_v) begin
        n_fail++; $display("FAIL indep_status n=%0d: got %h expected %h", n, v, exp_v);
      end
    end
    step();
    wr(A_STATUS, 32'd1);
    rd(A_STATUS, v);
    n_tests++;
    if (v !== 32'd2) begin
      n_fail++; $display("FAIL indep_clear_one: got %h expected 2", v);
    end
    step();
    step();
    rd(A_STATUS, v);
    n_tests++;
    if (v !== 32'd3) begin
      n_fail++; $display("FAIL indep_reset_ch0: got %h expected 3", v);
    end
    for (int a = 10; a < 16; a++) begin
      rd(4'(a), v);
      n_tests++;
      if (v !== 32'd0) begin
        n_fail++; $display("FAIL unmapped_read addr=%0d: got %h expected 0", a, v);
      end
    end
    rd(4'd3, v);
    n_tests++;
    if (v !== 32'd0) begin
      n_fail++; $display("FAIL reserved_read: got %h expected 0", v);
    end
  endtask

  task automatic test_random();
    logic [3:0]  a;
    logic [31:0] d;
    quiesce();
    for (int i = 0; i < 400; i++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) global_int_en = ~global_int_en;
      if ($urandom_range(0, 2) == 0) begin
        addr = a;
        step();
      end else begin
        if (a == A_LOAD0 || a == A_LOAD1) d = $urandom_range(0, 6);
        else if (a == A_PRE)              d = $urandom_range(0, 3);
        else                              d = $urandom;
        wr(a, d);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    quiesce();
    global_int_en = 1'b1;
    wr(A_LOAD0, 32'd1);
    wr(A_CTRL0, 32'd7);
    repeat (3) step();
    n_tests++;
    if (irq_pin !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_pre: got %b expected 1", irq_pin);
    end
    #2;
    clrn = 1'b0;
    #1;
    n_tests++;
    if (irq_pin !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_async_irq: got %b expected 0", irq_pin);
    end
    m_reset();
    @(posedge clk);
    #1;
    clrn = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), v);
      n_tests++;
      if (v !== 32'd0) begin
        n_fail++; $display("FAIL reset_mid_read addr=%0d: got %h expected 0", a, v);
      end
      step();
    end
    addr = A_STATUS;
    repeat (20) step();
    rd(A_STATUS, v);
    n_tests++;
    if (v !== 32'd0 || irq_pin !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_quiet: got status=%h irq=%b expected 0/0", v, irq_pin);
    end
  endtask

  initial begin
    m_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_periodic();
    test_oneshot();
    test_masking();
    test_collision();
    test_independence();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
